// File: rtl/dense_pkg.sv
// Shared types and default sizes for the dense-layer sequencer.
package dense_pkg;

    localparam int DENSE_DIM_W_DEF  = 12;
    localparam int DENSE_ADDR_W_DEF = 12;
    localparam int DENSE_N_PE_DEF   = 8;
    localparam int DENSE_RD_LAT_DEF = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        FLUSH = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dense_state_t;

endpackage

// File: rtl/dense_tile_ctr.sv
// Tile/lane bookkeeping: outputs still to be written, active-lane mask and
// the write-lane counter used while draining a tile.
module dense_tile_ctr
    import dense_pkg::*;
#(
    parameter int N_PE  = DENSE_N_PE_DEF,
    parameter int DIM_W = DENSE_DIM_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DIM_W-1:0]        load_dim,
    input  logic                    step,
    output logic [N_PE-1:0]         lane_mask,
    output logic [$clog2(N_PE)-1:0] wr_lane,
    output logic                    last_lane,
    output logic                    last_tile
);

    localparam int LANE_W = $clog2(N_PE);
    localparam logic [DIM_W-1:0] N_PE_D = DIM_W'(N_PE);
    localparam logic [DIM_W-1:0] ONE_D  = DIM_W'(1);

    logic [DIM_W-1:0]  rem_r;
    logic [DIM_W-1:0]  active_s;
    logic [LANE_W-1:0] lane_r;
    logic [N_PE-1:0]   mask_s;

    // Lanes used by the current tile: min(N_PE, remaining)
    always_comb begin
        if (rem_r > N_PE_D) begin
            active_s = N_PE_D;
        end else begin
            active_s = rem_r;
        end
    end

    // Thermometer mask over the active lanes
    always_comb begin
        mask_s = {N_PE{1'b0}};
        for (int l = 0; l < N_PE; l++) begin
            if (DIM_W'(l) < active_s) begin
                mask_s[l] = 1'b1;
            end else begin
                mask_s[l] = 1'b0;
            end
        end
    end

    // remaining drops by the whole tile once its last lane is written
    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_r  <= {DIM_W{1'b0}};
            lane_r <= {LANE_W{1'b0}};
        end else if (load) begin
            rem_r  <= load_dim;
            lane_r <= {LANE_W{1'b0}};
        end else if (step) begin
            if (last_lane) begin
                rem_r  <= rem_r - active_s;
                lane_r <= {LANE_W{1'b0}};
            end else begin
                lane_r <= lane_r + LANE_W'(1);
            end
        end
    end

    assign lane_mask = mask_s;
    assign wr_lane   = lane_r;
    assign last_lane = ((DIM_W'(lane_r) + ONE_D) == active_s);
    assign last_tile = (rem_r == active_s);

endmodule

// File: rtl/dense_seq.sv
// Dense-layer sequencer: walks output neurons in N_PE-wide tiles, issuing
// feature/weight reads, PE MAC enables and per-lane output writes.
module dense_seq
    import dense_pkg::*;
#(
    parameter int N_PE   = DENSE_N_PE_DEF,
    parameter int DIM_W  = DENSE_DIM_W_DEF,
    parameter int ADDR_W = DENSE_ADDR_W_DEF,
    parameter int RD_LAT = DENSE_RD_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stall,
    input  logic [DIM_W-1:0]        cfg_in_dim,
    input  logic [DIM_W-1:0]        cfg_out_dim,
    input  logic                    cfg_buf_sel,
    input  logic                    cfg_relu,
    output logic                    aybz_azby,
    output logic                    in_rd_en,
    output logic [ADDR_W-1:0]       in_rd_addr,
    output logic                    wt_rd_en,
    output logic [ADDR_W-1:0]       wt_rd_addr,
    output logic                    pe_clear,
    output logic                    pe_mac_en,
    output logic [N_PE-1:0]         pe_lane_mask,
    output logic                    pe_relu,
    output logic                    out_wr_en,
    output logic [$clog2(N_PE)-1:0] out_wr_lane,
    output logic [ADDR_W-1:0]       out_wr_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    dense_state_t      state_r;
    dense_state_t      state_nx_s;
    logic [DIM_W-1:0]  in_dim_r;
    logic [DIM_W-1:0]  mac_cnt_r;
    logic [ADDR_W-1:0] wt_addr_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic [LAT_W-1:0]  lat_cnt_r;
    logic [RD_LAT-1:0] mac_sr_r;
    logic              buf_sel_r;
    logic              relu_r;
    logic              zero_err_r;
    logic              accept_s;
    logic              zero_cfg_s;
    logic              mac_last_s;
    logic              lat_last_s;
    logic              last_lane_s;
    logic              last_tile_s;
    logic              wr_step_s;
    logic              rd_s;

    assign accept_s   = (state_r == IDLE) && start;
    assign zero_cfg_s = (cfg_in_dim == {DIM_W{1'b0}}) || (cfg_out_dim == {DIM_W{1'b0}});
    assign mac_last_s = (mac_cnt_r == (in_dim_r - DIM_ONE));
    assign lat_last_s = (lat_cnt_r == LAT_W'(RD_LAT - 1));
    assign rd_s       = (state_r == MAC);
    assign wr_step_s  = (state_r == WRITE) && !stall;

    dense_tile_ctr #(
        .N_PE  (N_PE),
        .DIM_W (DIM_W)
    ) u_tile_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .load_dim  (zero_cfg_s ? {DIM_W{1'b0}} : cfg_out_dim),
        .step      (wr_step_s),
        .lane_mask (pe_lane_mask),
        .wr_lane   (out_wr_lane),
        .last_lane (last_lane_s),
        .last_tile (last_tile_s)
    );

    // Next-state logic; stall freezes every state except IDLE and DONE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = zero_cfg_s ? DONE : CLEAR;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CLEAR: begin
                if (!stall) begin
                    state_nx_s = MAC;
                end else begin
                    state_nx_s = CLEAR;
                end
            end
            MAC: begin
                if (!stall && mac_last_s) begin
                    state_nx_s = FLUSH;
                end else begin
                    state_nx_s = MAC;
                end
            end
            FLUSH: begin
                if (!stall && lat_last_s) begin
                    state_nx_s = WRITE;
                end else begin
                    state_nx_s = FLUSH;
                end
            end
            WRITE: begin
                if (!stall && last_lane_s) begin
                    state_nx_s = last_tile_s ? DONE : CLEAR;
                end else begin
                    state_nx_s = WRITE;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Config latch and address counters; wt/out addresses run across tiles
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_dim_r   <= {DIM_W{1'b0}};
            mac_cnt_r  <= {DIM_W{1'b0}};
            wt_addr_r  <= {ADDR_W{1'b0}};
            out_addr_r <= {ADDR_W{1'b0}};
            lat_cnt_r  <= {LAT_W{1'b0}};
            buf_sel_r  <= 1'b0;
            relu_r     <= 1'b0;
            zero_err_r <= 1'b0;
        end else if (accept_s) begin
            in_dim_r   <= cfg_in_dim;
            mac_cnt_r  <= {DIM_W{1'b0}};
            wt_addr_r  <= {ADDR_W{1'b0}};
            out_addr_r <= {ADDR_W{1'b0}};
            lat_cnt_r  <= {LAT_W{1'b0}};
            buf_sel_r  <= cfg_buf_sel;
            relu_r     <= cfg_relu;
            zero_err_r <= zero_cfg_s;
        end else if (!stall) begin
            case (state_r)
                MAC: begin
                    wt_addr_r <= wt_addr_r + ADDR_W'(1);
                    mac_cnt_r <= mac_last_s ? {DIM_W{1'b0}} : (mac_cnt_r + DIM_ONE);
                end
                FLUSH: begin
                    lat_cnt_r <= lat_last_s ? {LAT_W{1'b0}} : (lat_cnt_r + LAT_W'(1));
                end
                WRITE: begin
                    out_addr_r <= out_addr_r + ADDR_W'(1);
                end
                default: begin
                    lat_cnt_r <= lat_cnt_r;
                end
            endcase
        end
    end

    // Read-latency pipe: a read issued now becomes a MAC RD_LAT live cycles later
    always_ff @(posedge clk) begin
        if (!rst) begin
            mac_sr_r <= {RD_LAT{1'b0}};
        end else if (!stall) begin
            mac_sr_r <= RD_LAT'({mac_sr_r, rd_s});
        end
    end

    assign aybz_azby   = buf_sel_r;
    assign pe_relu     = relu_r;
    assign in_rd_en    = rd_s && !stall;
    assign wt_rd_en    = rd_s && !stall;
    assign in_rd_addr  = ADDR_W'(mac_cnt_r);
    assign wt_rd_addr  = wt_addr_r;
    assign pe_clear    = (state_r == CLEAR) && !stall;
    assign pe_mac_en   = mac_sr_r[RD_LAT-1] && !stall;
    assign out_wr_en   = (state_r == WRITE) && !stall;
    assign out_wr_addr = out_addr_r;
    assign busy        = (state_r != IDLE);
    assign done        = (state_r == DONE);
    assign err         = (state_r == DONE) && zero_err_r;

endmodule

// File: tb/tb_dense_seq.sv
// Self-checking bench for dense_seq: directed scenarios plus randomized
// operations compared cycle by cycle against a tile-walk reference model.
module tb_dense_seq;

    localparam int N_PE   = 4;
    localparam int DIM_W  = 12;
    localparam int ADDR_W = 12;
    localparam int RD_LAT = 2;
    localparam int LW     = $clog2(N_PE);

    localparam int K_CLR = 1;
    localparam int K_MAC = 2;
    localparam int K_FL  = 3;
    localparam int K_WR  = 4;
    localparam int K_DN  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stall;
    logic [DIM_W-1:0]  cfg_in_dim;
    logic [DIM_W-1:0]  cfg_out_dim;
    logic              cfg_buf_sel;
    logic              cfg_relu;
    logic              aybz_azby;
    logic              in_rd_en;
    logic [ADDR_W-1:0] in_rd_addr;
    logic              wt_rd_en;
    logic [ADDR_W-1:0] wt_rd_addr;
    logic              pe_clear;
    logic              pe_mac_en;
    logic [N_PE-1:0]   pe_lane_mask;
    logic              pe_relu;
    logic              out_wr_en;
    logic [LW-1:0]     out_wr_lane;
    logic [ADDR_W-1:0] out_wr_addr;
    logic              busy;
    logic              done;
    logic              err;

    dense_seq #(.N_PE(N_PE), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .cfg_in_dim(cfg_in_dim), .cfg_out_dim(cfg_out_dim),
        .cfg_buf_sel(cfg_buf_sel), .cfg_relu(cfg_relu),
        .aybz_azby(aybz_azby), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .pe_clear(pe_clear),
        .pe_mac_en(pe_mac_en), .pe_lane_mask(pe_lane_mask), .pe_relu(pe_relu),
        .out_wr_en(out_wr_en), .out_wr_lane(out_wr_lane), .out_wr_addr(out_wr_addr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int ia;
        int wa;
        int ln;
        int oa;
        int mk;
        bit er;
        bit mac;
    } step_t;

    step_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({aybz_azby, in_rd_en, in_rd_addr, wt_rd_en, wt_rd_addr, pe_clear,
                    pe_mac_en, pe_lane_mask, pe_relu, out_wr_en, out_wr_lane,
                    out_wr_addr, busy, done, err});
    endfunction

    // One entry per live (non-stalled) cycle; a MAC retires RD_LAT live cycles after its read
    function automatic void push(input int kind, input int ia, input int wa, input int ln,
                                 input int oa, input int mk, input bit er);
        step_t s;
        s.kind = kind; s.ia = ia; s.wa = wa; s.ln = ln; s.oa = oa; s.mk = mk; s.er = er;
        s.mac  = (q.size() >= RD_LAT) && (q[q.size() - RD_LAT].kind == K_MAC);
        q.push_back(s);
    endfunction

    task automatic build(input int in_d, input int out_d);
        int rem;
        int act;
        int wt;
        int oa;
        int mk;
        q.delete();
        if (in_d == 0 || out_d == 0) begin
            push(K_DN, 0, 0, 0, 0, 0, 1'b1);
        end else begin
            rem = out_d; wt = 0; oa = 0;
            while (rem > 0) begin
                act = (rem > N_PE) ? N_PE : rem;
                mk  = (1 << act) - 1;
                push(K_CLR, 0, 0, 0, 0, mk, 1'b0);
                for (int i = 0; i < in_d; i++) begin
                    push(K_MAC, i, wt, 0, 0, mk, 1'b0);
                    wt++;
                end
                for (int f = 0; f < RD_LAT; f++) push(K_FL, 0, 0, 0, 0, mk, 1'b0);
                for (int l = 0; l < act; l++) begin
                    push(K_WR, 0, 0, l, oa, mk, 1'b0);
                    oa++;
                end
                rem -= act;
            end
            push(K_DN, 0, 0, 0, 0, 0, 1'b0);
        end
    endtask

    task automatic run_op(input int in_d, input int out_d, input bit bsel, input bit relu,
                          input int st_at, input int st_len, input bit st0, input int dup_at,
                          output int done_cyc, output int macs);
        step_t d;
        bit hold_in;
        bit hold;
        bit en;
        int idx;
        int c;
        build(in_d, out_d);
        done_cyc = -1; macs = 0; idx = 0; c = 1;
        @(posedge clk); #1;
        start = 1'b1; stall = st0;
        cfg_in_dim = DIM_W'(in_d); cfg_out_dim = DIM_W'(out_d);
        cfg_buf_sel = bsel; cfg_relu = relu;
        @(posedge clk); #1;
        while (idx < q.size()) begin
            hold_in     = (c >= st_at) && (c < st_at + st_len);
            stall       = hold_in;
            start       = (c == dup_at);
            cfg_in_dim  = DIM_W'($urandom_range(0, 7));
            cfg_out_dim = DIM_W'($urandom_range(0, 15));
            cfg_buf_sel = 1'($urandom_range(0, 1));
            cfg_relu    = 1'($urandom_range(0, 1));
            @(negedge clk);
            d    = q[idx];
            hold = hold_in && (d.kind != K_DN);
            en   = !hold;
            chk("pe_clear",  pe_clear,  en && d.kind == K_CLR);
            chk("in_rd_en",  in_rd_en,  en && d.kind == K_MAC);
            chk("wt_rd_en",  wt_rd_en,  en && d.kind == K_MAC);
            chk("pe_mac_en", pe_mac_en, en && d.mac);
            chk("out_wr_en", out_wr_en, en && d.kind == K_WR);
            chk("done",      done,      d.kind == K_DN);
            chk("err",       err,       d.kind == K_DN && d.er);
            chk("busy",      busy,      1'b1);
            chk("aybz_azby", aybz_azby, bsel);
            chk("pe_relu",   pe_relu,   relu);
            if (d.kind == K_MAC) begin
                chk("in_rd_addr", in_rd_addr, d.ia);
                chk("wt_rd_addr", wt_rd_addr, d.wa);
            end
            if (d.kind == K_WR) begin
                chk("out_wr_lane", out_wr_lane, d.ln);
                chk("out_wr_addr", out_wr_addr, d.oa);
            end
            if (d.kind != K_DN) chk("pe_lane_mask", pe_lane_mask, d.mk);
            if (pe_mac_en === 1'b1) macs++;
            if (done === 1'b1) done_cyc = c;
            if (!hold) idx++;
            @(posedge clk); #1;
            c++;
        end
        stall = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_strobes", {in_rd_en, wt_rd_en, pe_clear, pe_mac_en, out_wr_en, done, err}, 7'd0);
        chk("idle_aybz", aybz_azby, bsel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int mc;
        int in_d;
        int out_d;
        int st_at;
        int st_len;
        int base;
        int exp_dc;
        int tiles;
        int act;
        int rem;
        bit found;

        rst = 1'b0; start = 1'b0; stall = 1'b0;
        cfg_in_dim = '0; cfg_out_dim = '0; cfg_buf_sel = 1'b0; cfg_relu = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", all_outs(), 64'd0);
        rst = 1'b1;

        // Two full tiles
        run_op(4, 8, 1'b0, 1'b0, 0, 0, 1'b0, 0, dc, mc);
        chk("two_tiles_done_cyc", dc, 23);
        chk("two_tiles_macs", mc, 8);

        // Partial last tile: 10 + 8 tile cycles, DONE after
        run_op(3, 6, 1'b0, 1'b1, 0, 0, 1'b0, 0, dc, mc);
        chk("partial_done_cyc", dc, 19);
        chk("partial_macs", mc, 6);

        // Zero dimension
        run_op(0, 5, 1'b1, 1'b0, 0, 0, 1'b0, 0, dc, mc);
        chk("zero_done_cyc", dc, 1);
        chk("zero_macs", mc, 0);

        // Three-cycle stall in mid-MAC
        run_op(4, 8, 1'b0, 1'b1, 3, 3, 1'b0, 0, dc, mc);
        chk("stall_done_cyc", dc, 26);
        chk("stall_macs", mc, 8);

        // Second start while busy, and start together with stall
        run_op(4, 8, 1'b1, 1'b0, 0, 0, 1'b1, 5, dc, mc);
        chk("dup_start_done_cyc", dc, 23);

        // Reset in the middle of WRITE
        @(posedge clk); #1;
        start = 1'b1; cfg_in_dim = 12'd4; cfg_out_dim = 12'd8; cfg_buf_sel = 1'b1; cfg_relu = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_wr_en === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_write_seen", found, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", all_outs(), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_done", {busy, done}, 2'b00);
        end
        run_op(4, 8, 1'b1, 1'b0, 0, 0, 1'b0, 0, dc, mc);
        chk("bufsel_done_cyc", dc, 23);

        // Randomized operations
        for (int k = 0; k < 10; k++) begin
            in_d   = $urandom_range(0, 5);
            out_d  = $urandom_range(0, 13);
            st_at  = $urandom_range(1, 25);
            st_len = $urandom_range(0, 4);
            run_op(in_d, out_d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   st_at, st_len, 1'($urandom_range(0, 1)), $urandom_range(1, 20), dc, mc);
            tiles = 0; base = 1; rem = out_d;
            if (in_d != 0 && out_d != 0) begin
                while (rem > 0) begin
                    act = (rem > N_PE) ? N_PE : rem;
                    base += 1 + in_d + RD_LAT + act;
                    rem -= act;
                    tiles++;
                end
            end
            exp_dc = base;
            for (int c2 = 1; c2 < exp_dc; c2++) begin
                if (c2 >= st_at && c2 < st_at + st_len) exp_dc++;
            end
            chk("rnd_done_cyc", dc, exp_dc);
            chk("rnd_macs", mc, in_d * tiles);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
